sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port between the core's instruction-fetch requester (IF stage) and its load/store requester (EXE/MEM stages).
- Sits between the CPU core and the single memory/bridge port.
- Arbitrates new requests and locks the grant until the address handshake completes.
- Tracks outstanding transactions in an in-order tag FIFO so each data_ok/rdata return goes to the requester that issued it.

Parameters:
DEPTH, 4, max outstanding accepted-but-unreturned transactions (tag FIFO depth, >=2)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
inst_sram_req  in  1  fetch request (read only; wr=0, size=2 implied)
inst_sram_addr  in  32  fetch address
inst_sram_addr_ok  out  1  fetch request accepted
inst_sram_data_ok  out  1  fetch data returned
inst_sram_rdata  out  32  fetch data (= mem_rdata)
data_sram_req  in  1  load/store request
data_sram_wr / size / wstrb / addr / wdata  in  1/2/4/32/32  load/store payload
data_sram_addr_ok  out  1  load/store request accepted
data_sram_data_ok  out  1  load data returned / store acknowledged
data_sram_rdata  out  32  load data (= mem_rdata)
mem_req  out  1  request to memory
mem_wr / size / wstrb / addr / wdata  out  1/2/4/32/32  muxed payload (inst: 0/2/0/addr/0)
mem_addr_ok  in  1  memory accepted request
mem_data_ok  in  1  memory returns response (in order)
mem_rdata  in  32  response data

Behaviour:
- Clock is clk; reset is resetn, synchronous, active-low.
- Reset clears:
  - lock = 0
  - tag FIFO rd/wr pointers = 0, count = 0
  - rr_last = 0
- Outputs during and after reset: mem_req, both addr_ok and both data_ok are 0.
- Zero added latency: request, addr_ok, data_ok and rdata paths are combinational from registered state.
- Grant selection (lock=0):
  - data wins if data_sram_req=1, else inst.
  - Selected source drives mem_req and payload.
- Lock:
  - Set when mem_req=1 and mem_addr_ok=0; record the granted source in grant_src.
  - While lock=1, mem_req and payload come from grant_src only; the other requester is never granted, even at higher priority.
  - Cleared on the cycle mem_addr_ok=1.
- Requesters follow the SRAM-like rule: hold req and payload stable until addr_ok.
- addr_ok routing:
  - {inst,data}_sram_addr_ok = mem_addr_ok & mem_req & (granted source matches).
  - The non-granted source sees 0.
- Push: on mem_req & mem_addr_ok, push source id into the FIFO (0 = inst, 1 = data); count +1.
- Pop:
  - On mem_data_ok with count>0, pop the head.
  - Assert data_ok only for the head source, the same cycle.
  - rdata is broadcast to both requesters.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: when count==DEPTH, force mem_req=0, even if a pop occurs that cycle. A new grant is allowed the next cycle.
- Empty: mem_data_ok with count==0 is ignored; both data_ok stay 0 and no pointer moves.
- Pointer wrap-around: modulo DEPTH.
- Reset mid-operation: all outstanding tags are dropped; late mem_data_ok after reset is treated as the empty case.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- When defined:
  - If both requesters are present and lock=0, grant the source not granted last (rr_last).
  - rr_last updates on every accepted handshake.
  - With a single requester, that requester wins.
- When undefined: fixed data-over-inst priority; rr_last logic is absent.

Test Plan:
- Inst only, addr 0x1C000000, mem_addr_ok same cycle, mem_data_ok next cycle with 0x02800000 -> inst_sram_addr_ok=1 in cycle 0; inst_sram_data_ok=1 and inst_sram_rdata=0x02800000 in cycle 1; data_sram_* strobes stay 0.
- Both req in the same cycle, mem_addr_ok=1 (fixed priority) -> data granted first (mem_addr = data address); inst granted next cycle; returns 0xAAAA then 0xBBBB route data then inst.
- Inst granted with mem_addr_ok held 0 for 3 cycles while data_req rises in cycle 1 -> mem_addr stays the inst address until acceptance; data is granted only after.
- DEPTH=4: four inst pushes with no data_ok -> count=4, mem_req=0 with inst_req still 1. One mem_data_ok -> mem_req reasserts the next cycle.
- mem_data_ok pulse with FIFO empty -> no data_ok asserted, count stays 0. Then resetn=0 for 1 cycle with 2 outstanding -> count=0, later mem_data_ok ignored.
- SRAM_ARB_RR_EN defined, both requesting continuously with addr_ok always 1 -> grants alternate data, inst, data, inst.

Source files
------------

// File: rtl/sram_like_if.sv
// SRAM-like request/response bundle shared by the fetch, load/store and memory sides.
interface sram_like_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and load/store, routing returns in order.
// Optional round-robin grant between the two requesters is enabled with `define SRAM_ARB_RR_EN.
module sram_like_arbiter #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   sram_like_if.slave  inst_sram,
   sram_like_if.slave  data_sram,
   sram_like_if.master mem
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_grant_src;
   logic               w_grant_src_nxt;
   logic [DEPTH-1:0]   r_tags;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic               w_full;
   logic               w_arb_src;
   logic               w_sel_src;
   logic               w_src_req;
   logic               w_push;
   logic               w_pop;
   logic               w_head;

   // Source id convention: 0 = instruction fetch, 1 = load/store.
`ifdef SRAM_ARB_RR_EN
   logic               r_rr_last;

   always_comb begin
      w_arb_src = data_sram.req;
      if (inst_sram.req && data_sram.req) begin
         w_arb_src = ~r_rr_last;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rr_last <= 1'b0;
      end else if (w_push) begin
         r_rr_last <= w_sel_src;
      end
   end
`else
   assign w_arb_src = data_sram.req;
`endif

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_sel_src = (r_state == ST_LOCKED) ? r_grant_src : w_arb_src;
   assign w_src_req = w_sel_src ? data_sram.req : inst_sram.req;

   // A full tag FIFO blocks new requests even when a return frees a slot this cycle.
   assign mem.req   = resetn & w_src_req & ~w_full;
   assign mem.wr    = w_sel_src ? data_sram.wr    : 1'b0;
   assign mem.size  = w_sel_src ? data_sram.size  : 2'd2;
   assign mem.wstrb = w_sel_src ? data_sram.wstrb : 4'd0;
   assign mem.addr  = w_sel_src ? data_sram.addr  : inst_sram.addr;
   assign mem.wdata = w_sel_src ? data_sram.wdata : 32'd0;

   assign w_push = mem.req & mem.addr_ok;
   assign w_pop  = resetn & mem.data_ok & (r_count != CNT_W'(0));
   assign w_head = r_tags[r_rd_ptr];

   assign inst_sram.addr_ok = w_push & ~w_sel_src;
   assign data_sram.addr_ok = w_push &  w_sel_src;
   assign inst_sram.data_ok = w_pop  & ~w_head;
   assign data_sram.data_ok = w_pop  &  w_head;
   assign inst_sram.rdata   = mem.rdata;
   assign data_sram.rdata   = mem.rdata;

   // Grant lock: holds the stalled source on the port until its address is accepted.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= ST_OPEN;
         r_grant_src <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant_src <= w_grant_src_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_src_nxt = r_grant_src;
      case (r_state)
         ST_OPEN: begin
            if (mem.req && !mem.addr_ok) begin
               w_state_nxt     = ST_LOCKED;
               w_grant_src_nxt = w_sel_src;
            end
         end
         ST_LOCKED: begin
            if (mem.addr_ok) begin
               w_state_nxt = ST_OPEN;
            end
         end
         default: w_state_nxt = ST_OPEN;
      endcase
   end

   // In-order tag FIFO of outstanding transactions.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_tags[r_wr_ptr] <= w_sel_src;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed and randomized check of sram_like_arbiter against a queue-based reference model.
// Build with +define+SRAM_ARB_RR_EN to exercise the round-robin grant variant.
module tb_sram_like_arbiter;

   localparam int unsigned DEPTH = 4;

   logic clk;
   logic resetn;

   sram_like_if inst_if ();
   sram_like_if data_if ();
   sram_like_if mem_if ();

   sram_like_arbiter #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .inst_sram (inst_if),
      .data_sram (data_if),
      .mem       (mem_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Stimulus state
   bit          t_rst_n;
   bit          t_inst_req;
   logic [31:0] t_inst_addr;
   bit          t_data_req;
   bit          t_data_wr;
   logic [1:0]  t_data_size;
   logic [3:0]  t_data_wstrb;
   logic [31:0] t_data_addr;
   logic [31:0] t_data_wdata;
   bit          t_addr_ok;
   bit          t_mem_dok;
   logic [31:0] t_rdata;

   // Reference model: outstanding source ids in issue order, pending stalled grant, last grant
   bit q[$];
   int m_lock;
   bit m_last;

   // Observations from the latest step
   bit          ob_mem_req;
   logic [31:0] ob_mem_addr;
   bit          ob_inst_aok;
   bit          ob_data_aok;
   bit          ob_inst_dok;
   bit          ob_data_dok;
   bit          acc_inst;
   bit          acc_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: drive after the falling edge, check combinational outputs, advance the model.
   task automatic step();
      bit          e_req;
      bit          e_pop;
      bit          e_head;
      int          src;
      @(negedge clk);
      resetn         = t_rst_n;
      inst_if.req    = t_inst_req;
      inst_if.addr   = t_inst_addr;
      inst_if.wr     = 1'b0;
      inst_if.size   = 2'd2;
      inst_if.wstrb  = 4'd0;
      inst_if.wdata  = 32'd0;
      data_if.req    = t_data_req;
      data_if.wr     = t_data_wr;
      data_if.size   = t_data_size;
      data_if.wstrb  = t_data_wstrb;
      data_if.addr   = t_data_addr;
      data_if.wdata  = t_data_wdata;
      mem_if.addr_ok = t_addr_ok;
      mem_if.data_ok = t_mem_dok;
      mem_if.rdata   = t_rdata;
      #1;
      if (m_lock >= 0) src = m_lock;
      else if (t_inst_req && t_data_req) begin
`ifdef SRAM_ARB_RR_EN
         src = m_last ? 0 : 1;
`else
         src = 1;
`endif
      end else src = t_data_req ? 1 : 0;
      e_req  = t_rst_n && (q.size() < DEPTH) && ((src == 1) ? t_data_req : t_inst_req);
      e_pop  = t_rst_n && t_mem_dok && (q.size() > 0);
      e_head = (q.size() > 0) ? q[0] : 1'b0;

      ob_mem_req  = mem_if.req;
      ob_mem_addr = mem_if.addr;
      ob_inst_aok = inst_if.addr_ok;
      ob_data_aok = data_if.addr_ok;
      ob_inst_dok = inst_if.data_ok;
      ob_data_dok = data_if.data_ok;

      chk("mem_req", 32'(mem_if.req), 32'(e_req));
      if (e_req) begin
         chk("mem_addr",  mem_if.addr, (src == 1) ? t_data_addr : t_inst_addr);
         chk("mem_wr",    32'(mem_if.wr),    (src == 1) ? 32'(t_data_wr)    : 32'd0);
         chk("mem_size",  32'(mem_if.size),  (src == 1) ? 32'(t_data_size)  : 32'd2);
         chk("mem_wstrb", 32'(mem_if.wstrb), (src == 1) ? 32'(t_data_wstrb) : 32'd0);
         chk("mem_wdata", mem_if.wdata, (src == 1) ? t_data_wdata : 32'd0);
      end
      chk("inst_addr_ok", 32'(inst_if.addr_ok), 32'(e_req && t_addr_ok && src == 0));
      chk("data_addr_ok", 32'(data_if.addr_ok), 32'(e_req && t_addr_ok && src == 1));
      chk("inst_data_ok", 32'(inst_if.data_ok), 32'(e_pop && !e_head));
      chk("data_data_ok", 32'(data_if.data_ok), 32'(e_pop && e_head));
      chk("inst_rdata", inst_if.rdata, t_rdata);
      chk("data_rdata", data_if.rdata, t_rdata);

      acc_inst = e_req && t_addr_ok && src == 0;
      acc_data = e_req && t_addr_ok && src == 1;
      @(posedge clk);
      if (!t_rst_n) begin
         q.delete();
         m_lock = -1;
         m_last = 1'b0;
      end else begin
         if (e_pop) void'(q.pop_front());
         if (e_req && t_addr_ok) begin
            q.push_back(src[0]);
            m_lock = -1;
            m_last = src[0];
         end else if (e_req) begin
            m_lock = src;
         end
      end
   endtask

   initial begin
      m_lock = -1;
      m_last = 1'b0;
      t_rst_n = 1'b0; t_inst_req = 1'b0; t_inst_addr = '0;
      t_data_req = 1'b0; t_data_wr = 1'b0; t_data_size = 2'd2; t_data_wstrb = 4'hf;
      t_data_addr = '0; t_data_wdata = '0;
      t_addr_ok = 1'b0; t_mem_dok = 1'b0; t_rdata = '0;
      resetn = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_mem_req", 32'(ob_mem_req), 32'd0);
      t_rst_n = 1'b1;

      // Single fetch: accepted in cycle 0, data returned in cycle 1
      t_inst_req = 1'b1; t_inst_addr = 32'h1C00_0000; t_addr_ok = 1'b1;
      step();
      chk("tp1_inst_aok", 32'(ob_inst_aok), 32'd1);
      t_inst_req = 1'b0; t_mem_dok = 1'b1; t_rdata = 32'h0280_0000;
      step();
      chk("tp1_inst_dok", 32'(ob_inst_dok), 32'd1);
      chk("tp1_data_dok", 32'(ob_data_dok), 32'd0);
      t_mem_dok = 1'b0;

      // Simultaneous requests: data first, then inst; returns routed in order
      t_inst_req = 1'b1; t_inst_addr = 32'h1C00_0004;
      t_data_req = 1'b1; t_data_addr = 32'h8000_0010; t_data_wr = 1'b1; t_data_wdata = 32'h1234_5678;
      step();
      chk("tp2_first_addr", ob_mem_addr, 32'h8000_0010);
      t_data_req = 1'b0;
      step();
      chk("tp2_second_addr", ob_mem_addr, 32'h1C00_0004);
      t_inst_req = 1'b0; t_mem_dok = 1'b1; t_rdata = 32'h0000_AAAA;
      step();
      chk("tp2_ret1_data", 32'(ob_data_dok), 32'd1);
      t_rdata = 32'h0000_BBBB;
      step();
      chk("tp2_ret2_inst", 32'(ob_inst_dok), 32'd1);
      t_mem_dok = 1'b0;

      // Lock: inst stalls three cycles while data arrives, data waits its turn
      t_inst_req = 1'b1; t_inst_addr = 32'h1C00_0008; t_addr_ok = 1'b0;
      step();
      t_data_req = 1'b1; t_data_addr = 32'h8000_0020; t_data_wr = 1'b0;
      step();
      step();
      chk("tp3_locked_addr", ob_mem_addr, 32'h1C00_0008);
      chk("tp3_data_blocked", 32'(ob_data_aok), 32'd0);
      t_addr_ok = 1'b1;
      step();
      chk("tp3_inst_accept", 32'(ob_inst_aok), 32'd1);
      t_inst_req = 1'b0;
      step();
      chk("tp3_data_accept", 32'(ob_data_aok), 32'd1);
      t_data_req = 1'b0; t_mem_dok = 1'b1;
      step();
      step();
      t_mem_dok = 1'b0;

      // Full FIFO blocks requests, including on the cycle a return frees a slot
      t_inst_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         t_inst_addr = 32'h1C00_0100 + 32'(i * 4);
         step();
      end
      step();
      chk("tp4_full_req", 32'(ob_mem_req), 32'd0);
      t_mem_dok = 1'b1;
      step();
      chk("tp4_full_pop_req", 32'(ob_mem_req), 32'd0);
      t_mem_dok = 1'b0;
      step();
      chk("tp4_resume_req", 32'(ob_mem_req), 32'd1);
      t_inst_req = 1'b0; t_mem_dok = 1'b1;
      for (int i = 0; i < 4; i++) step();

      // Return with nothing outstanding is ignored
      step();
      chk("tp5_empty_inst", 32'(ob_inst_dok), 32'd0);
      chk("tp5_empty_data", 32'(ob_data_dok), 32'd0);
      t_mem_dok = 1'b0; t_inst_req = 1'b1;
      step();
      step();
      t_inst_req = 1'b0; t_rst_n = 1'b0;
      step();
      chk("tp5_rst_req", 32'(ob_mem_req), 32'd0);
      t_rst_n = 1'b1; t_mem_dok = 1'b1;
      step();
      chk("tp5_late_dok", 32'(ob_inst_dok), 32'd0);
      t_mem_dok = 1'b0;

`ifdef SRAM_ARB_RR_EN
      // Round robin: both requesting continuously alternate data, inst, data, inst
      t_inst_req = 1'b1; t_data_req = 1'b1; t_addr_ok = 1'b1; t_mem_dok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_data_turn", 32'(ob_data_aok), (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      t_inst_req = 1'b0; t_data_req = 1'b0;
      for (int i = 0; i < 4; i++) step();
      t_mem_dok = 1'b0;
`endif

      // Randomized traffic obeying the hold-until-addr_ok rule
      for (int n = 0; n < 800; n++) begin
         if (!t_inst_req || acc_inst) begin
            t_inst_req  = 1'($urandom_range(0, 1));
            t_inst_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!t_data_req || acc_data) begin
            t_data_req   = 1'($urandom_range(0, 1));
            t_data_addr  = $urandom;
            t_data_wr    = 1'($urandom_range(0, 1));
            t_data_size  = 2'($urandom_range(0, 2));
            t_data_wstrb = 4'($urandom);
            t_data_wdata = $urandom;
         end
         t_addr_ok = ($urandom_range(0, 2) != 0);
         t_mem_dok = 1'($urandom_range(0, 1));
         t_rdata   = $urandom;
         if ($urandom_range(0, 99) == 0) begin
            t_rst_n = 1'b0; t_inst_req = 1'b0; t_data_req = 1'b0;
            step();
            t_rst_n = 1'b1;
         end else begin
            step();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
